aes_decryptor: RTL

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that recovers plaintext from ciphertext produced by the team's pipelined AES encryption core. It uses one shared inverse round datapath over 10 cycles instead of an unrolled pipeline. Round keys are derived on the fly: a forward expansion reaches k10, then a reverse key schedule walks back down to k0. It sits on the receive side of the crypto path and uses valid/ready handshakes on input and output.

---
 rtl/aes_pkg.sv | 167 ++++++++++++++++
 rtl/aes_inv_round.sv | 19 +
 rtl/aes_decryptor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared package: S-box tables, Rcon, GF(2^8) helpers,
// inverse-round transforms, key-schedule steps and FSM state encodings.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEXP  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Rcon[1..10]; index 0 and 11..15 are never used
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]],
                SBOX[w[15:8]],  SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // byte (row r, col c) lives at bit 127-8*(4c+r)
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                             ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                             ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                             ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // k_{i} -> k_{i+1}
    function automatic logic [127:0] key_fwd(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // k_{i+1} -> k_{i}; rc is Rcon[i+1]
    function automatic logic [127:0] key_rev(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
// Ports: i_state/i_round_key in, i_last_round skips InvMixColumns, o_state out.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last_round,
    output logic [127:0] o_state
);

    logic [127:0] added;

    always_comb begin
        added   = inv_sub_bytes(inv_shift_rows(i_state)) ^ i_round_key;
        o_state = i_last_round ? added : inv_mix_columns(added);
    end

endmodule

// File: rtl/aes_decryptor.sv
// Iterative AES-128 inverse cipher with on-the-fly reverse key schedule.
// Ports: clk/rst_n, in valid/ready + cipher_text/key_in, out valid/ready + data.
module aes_decryptor
    import aes_pkg::*;
#(
    parameter int unsigned KEY_CACHE = 1
) (
    input  logic         i_aes_decryptor_clk,
    input  logic         i_aes_decryptor_rst_n,
    input  logic         i_aes_decryptor_in_valid,
    output logic         o_aes_decryptor_in_ready,
    input  logic [127:0] i_aes_decryptor_cipher_text,
    input  logic [127:0] i_aes_decryptor_key_in,
    output logic         o_aes_decryptor_out_valid,
    input  logic         i_aes_decryptor_out_ready,
    output logic [127:0] o_aes_decryptor_data_decrypted
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] key_orig_q, key_orig_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_k10_q, cache_k10_d;
    logic         cache_vld_q, cache_vld_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] data_q, data_d;

    logic [7:0]   rc_val;
    logic [127:0] key_next;
    logic [127:0] key_prev;
    logic [127:0] rnd_out;
    logic         last_rnd;
    logic         cache_hit;

    // both schedule directions at step rc use Rcon[rc+1]
    assign rc_val   = rcon(rc_q + 4'd1);
    assign key_next = key_fwd(key_q, rc_val);
    assign key_prev = key_rev(key_q, rc_val);
    assign last_rnd = (rc_q == 4'd0);

    assign cache_hit = (KEY_CACHE != 0) && cache_vld_q
                    && (i_aes_decryptor_key_in == cache_key_q);

    aes_inv_round u_inv_round (
        .i_state      (blk_q),
        .i_round_key  (key_prev),
        .i_last_round (last_rnd),
        .o_state      (rnd_out)
    );

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        key_d       = key_q;
        key_orig_d  = key_orig_q;
        rc_d        = rc_q;
        cache_key_d = cache_key_q;
        cache_k10_d = cache_k10_q;
        cache_vld_d = cache_vld_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (i_aes_decryptor_in_valid) begin
                    blk_d      = i_aes_decryptor_cipher_text;
                    key_d      = i_aes_decryptor_key_in;
                    key_orig_d = i_aes_decryptor_key_in;
                    rc_d       = 4'd0;
                    fsm_d      = ST_KEXP;
                    if (cache_hit) begin
                        blk_d = i_aes_decryptor_cipher_text ^ cache_k10_q;
                        key_d = cache_k10_q;
                        rc_d  = 4'd9;
                        fsm_d = ST_ROUND;
                    end
                end
            end
            ST_KEXP: begin
                key_d = key_next;
                rc_d  = rc_q + 4'd1;
                if (rc_q == 4'd9) begin
                    blk_d       = blk_q ^ key_next;
                    cache_key_d = key_orig_q;
                    cache_k10_d = key_next;
                    cache_vld_d = 1'b1;
                    rc_d        = 4'd9;
                    fsm_d       = ST_ROUND;
                end
            end
            ST_ROUND: begin
                key_d = key_prev;
                blk_d = rnd_out;
                rc_d  = rc_q - 4'd1;
                if (last_rnd) begin
                    data_d      = rnd_out;
                    out_valid_d = 1'b1;
                    rc_d        = 4'd0;
                    fsm_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_aes_decryptor_out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_aes_decryptor_clk or negedge i_aes_decryptor_rst_n) begin
        if (!i_aes_decryptor_rst_n) begin
            fsm_q       <= ST_IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            key_orig_q  <= '0;
            rc_q        <= '0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
            cache_vld_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            key_orig_q  <= key_orig_d;
            rc_q        <= rc_d;
            cache_key_q <= cache_key_d;
            cache_k10_q <= cache_k10_d;
            cache_vld_q <= cache_vld_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    assign o_aes_decryptor_in_ready       = (fsm_q == ST_IDLE);
    assign o_aes_decryptor_out_valid      = out_valid_q;
    assign o_aes_decryptor_data_decrypted = data_q;

endmodule
